uart_rx_word: RTL and testbench

Receive-side counterpart of the UART transmitter. Consumes the serial line and deserialises 8N1 frames into bytes, then packs four consecutive bytes into one 32-bit word. Sits directly downstream of the transmitter: in loopback benches, on the SoC's receive path. Presents completed words on a valid/ready handshake, with framing-error and overrun status.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_byte.sv | 123 ++++++++++++
 rtl/uart_rx_word.sv | 130 +++++++++++++
 tb/tb_uart_rx_word.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-FSM state encodings (common with the transmitter) and framing constants.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int BYTES_PER_WORD       = 4;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: line synchroniser, bit FSM, one-cycle byte_valid / frame_err strobes.
// Exposes rx_idle only when UART_RX_TIMEOUT_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for a falling edge on the synchronised line
// ST_START | counting to mid start bit to reject glitches
// ST_DATA  | sampling 8 data bits LSB first, one per bit period
// ST_STOP  | sampling mid stop bit; high = byte good, low = framing error
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial,
    output logic [DATA_BITS-1:0] byte_out,
    output logic                 byte_valid,
    output logic                 frame_err
`ifdef UART_RX_TIMEOUT_EN
    ,
    output logic                 rx_idle
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q;
    logic                 rx_prev_q, rx_prev_d;
    logic [1:0]           flush_q, flush_d;
    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tc;

    assign tc       = (cnt_q == '0);
    assign byte_out = shift_q;
`ifdef UART_RX_TIMEOUT_EN
    assign rx_idle  = (state_q == ST_IDLE);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        // The reset-high synchroniser contents are not a real line level, so the
        // edge detector stays disarmed until they have been flushed out.
        flush_d    = (flush_q == 2'd0) ? 2'd0 : flush_q - 2'd1;
        rx_prev_d  = (flush_q == 2'd0) ? sync2_q : 1'b0;
        if (state_q != ST_IDLE && !tc) begin
            cnt_d = cnt_q - 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !sync2_q) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end
            ST_START: begin
                if (tc) begin
                    if (sync2_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_FULL;
                        bit_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (tc) begin
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tc) begin
                    state_d    = ST_IDLE;
                    byte_valid = sync2_q;
                    frame_err  = !sync2_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b0;
            flush_q   <= 2'd2;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            sync1_q   <= serial;
            sync2_q   <= sync1_q;
            rx_prev_q <= rx_prev_d;
            flush_q   <= flush_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/uart_rx_word.sv
// Packs four received bytes into a 32-bit word with valid/ready handshake, frame_err and sticky overrun.
// UART_RX_TIMEOUT_EN adds an idle timeout that silently drops a partial word.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
`ifdef UART_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_BITS = 20
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        serial,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_WORD - 1);

    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_byte_valid, rx_frame_err;
    logic [1:0]           idx_q, idx_d;
    logic [23:0]          shadow_q, shadow_d;
    logic [31:0]          word_q, word_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 accept;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    logic            rx_idle;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
        .clk        (clk),
        .reset      (reset),
        .serial     (serial),
        .byte_out   (rx_byte),
        .byte_valid (rx_byte_valid),
        .frame_err  (rx_frame_err)
`ifdef UART_RX_TIMEOUT_EN
        ,
        .rx_idle    (rx_idle)
`endif
    );

    assign accept     = valid_q & word_ready;
    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

    always_comb begin
        idx_d    = idx_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        valid_d  = valid_q & ~accept;
        ferr_d   = 1'b0;
        ovr_d    = ovr_q;
`ifdef UART_RX_TIMEOUT_EN
        to_cnt_d = TO_LOAD;
        if (rx_idle && idx_q != 2'd0) begin
            if (to_cnt_q == '0) begin
                idx_d    = 2'd0;
                shadow_d = '0;
            end else begin
                to_cnt_d = to_cnt_q - 1'b1;
            end
        end
`endif
        if (rx_frame_err) begin
            idx_d  = 2'd0;
            ferr_d = 1'b1;
        end else if (rx_byte_valid) begin
            if (idx_q == IDX_LAST) begin
                idx_d = 2'd0;
                // A word arriving in the same cycle as acceptance replaces the old one cleanly.
                if (!valid_q || accept) begin
                    word_d  = {shadow_q, rx_byte};
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
                case (idx_q)
                    2'd0:    shadow_d[23:16] = rx_byte;
                    2'd1:    shadow_d[15:8]  = rx_byte;
                    default: shadow_d[7:0]   = rx_byte;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= 2'd0;
            shadow_q <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= TO_LOAD;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at 16 clocks per bit; expected values are hand-computed constants.
module tb_uart_rx_word;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        serial = 1'b1;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        frame_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    int acc_cnt = 0;
    int valid_cyc = 0;
    int fe_cnt = 0;
    logic [31:0] last_acc = '0;

    uart_rx_word #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial     (serial),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (word_valid && word_ready) begin
            acc_cnt  <= acc_cnt + 1;
            last_acc <= word_out;
        end
        if (word_valid) valid_cyc <= valid_cyc + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        serial = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            serial = b[i];
            repeat (CPB) @(posedge clk);
        end
        serial = stop_bit;
        repeat (CPB) @(posedge clk);
        serial = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    int a0, v0, f0;
    logic [31:0] exp_to;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_word_out", word_out, 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        repeat (2 * CPB) @(posedge clk);

        // Single word, consumer always ready
        a0 = acc_cnt; v0 = valid_cyc;
        send_word(32'h12345678);
        @(negedge clk);
        check("single_word", last_acc, 32'h12345678);
        check("single_acc_cnt", 32'(acc_cnt - a0), 32'd1);
        check("single_valid_cycles", 32'(valid_cyc - v0), 32'd1);

        // Framing error on the second byte restarts word assembly
        f0 = fe_cnt; a0 = acc_cnt;
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        check("ferr_pulse_count", 32'(fe_cnt - f0), 32'd1);
        check("ferr_no_word", 32'(acc_cnt - a0), 32'd0);
        send_word(32'hA1B2C3D4);
        @(negedge clk);
        check("ferr_next_word", last_acc, 32'hA1B2C3D4);
        check("ferr_next_acc_cnt", 32'(acc_cnt - a0), 32'd1);

        // Short low glitch on idle line
        f0 = fe_cnt; a0 = acc_cnt;
        serial = 1'b0;
        repeat (4) @(posedge clk);
        serial = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        check("glitch_no_ferr", 32'(fe_cnt - f0), 32'd0);
        send_word(32'hC0FFEE11);
        @(negedge clk);
        check("glitch_word", last_acc, 32'hC0FFEE11);
        check("glitch_acc_cnt", 32'(acc_cnt - a0), 32'd1);

        // Long idle gap inside a word
`ifdef UART_RX_TIMEOUT_EN
        exp_to = 32'h01020304;
`else
        exp_to = 32'hAABB0102;
`endif
        a0 = acc_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        repeat (21 * CPB) @(posedge clk);
        send_word(32'h01020304);
        @(negedge clk);
        check("timeout_word", last_acc, exp_to);
        check("timeout_acc_cnt", 32'(acc_cnt - a0), 32'd1);

        // Reset mid-frame with a stale word_out
        word_ready = 1'b0;
        serial = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_word_out", word_out, 32'h0);
        check("midrst_word_valid", 32'(word_valid), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        check("midrst_overrun", 32'(overrun), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        word_ready = 1'b1;
        repeat (10) @(posedge clk);
        serial = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        a0 = acc_cnt; f0 = fe_cnt;
        send_word(32'h5A697887);
        @(negedge clk);
        check("postrst_word", last_acc, 32'h5A697887);
        check("postrst_acc_cnt", 32'(acc_cnt - a0), 32'd1);
        check("postrst_no_ferr", 32'(fe_cnt - f0), 32'd0);

        // Back-pressure then overrun
        word_ready = 1'b0;
        send_word(32'h87654321);
        @(negedge clk);
        check("bp_valid", 32'(word_valid), 32'h1);
        check("bp_word", word_out, 32'h87654321);
        repeat (20) @(negedge clk);
        check("bp_word_stable", word_out, 32'h87654321);
        check("bp_no_overrun", 32'(overrun), 32'h0);
        send_word(32'h1E2D3C4B);
        @(negedge clk);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_word_kept", word_out, 32'h87654321);
        check("ovr_valid", 32'(word_valid), 32'h1);
        a0 = acc_cnt;
        word_ready = 1'b1;
        @(negedge clk);
        check("accept_valid_low", 32'(word_valid), 32'h0);
        check("accept_word", last_acc, 32'h87654321);
        check("accept_acc_cnt", 32'(acc_cnt - a0), 32'd1);
        check("ovr_sticky", 32'(overrun), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
